// File: rtl/gen_padded_multi_if.sv
`default_nettype none
// ============================================================================
//  Module      : gen_padded_multi_if
//  Description : Handshake and SRAM bundle between the multi-block SHA256
//                padder, the message SRAM and the compression core.
//                master = padder side, slave = SRAM/core side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface gen_padded_multi_if #(
    parameter int MAX_MESSAGE_LENGTH = 183,
    parameter int SYMBOL_WIDTH       = 8
);
    localparam int ADDR_W     = $clog2(MAX_MESSAGE_LENGTH);
    localparam int LEN_W      = $clog2(MAX_MESSAGE_LENGTH + 1);
    localparam int MAX_BLOCKS = (MAX_MESSAGE_LENGTH + 8) / 64 + 1;
    localparam int BLK_W      = ($clog2(MAX_BLOCKS) < 1) ? 1 : $clog2(MAX_BLOCKS);

    logic                    main_go_sig;
    logic [LEN_W-1:0]        msg_len;
    logic [SYMBOL_WIDTH-1:0] msg_mem_data;
    logic                    blk_ack;
    logic                    finish_sig;
    logic                    regop_msg_mem_en;
    logic [ADDR_W-1:0]       regop_msg_mem_addr;
    logic [511:0]            regop_pad_reg;
    logic                    regop_pad_rdy;
    logic [BLK_W-1:0]        regop_blk_idx;
    logic                    regop_last_blk;
    logic                    regop_len_err;

    modport master (
        input  main_go_sig, msg_len, msg_mem_data, blk_ack, finish_sig,
        output regop_msg_mem_en, regop_msg_mem_addr, regop_pad_reg,
               regop_pad_rdy, regop_blk_idx, regop_last_blk, regop_len_err
    );

    modport slave (
        output main_go_sig, msg_len, msg_mem_data, blk_ack, finish_sig,
        input  regop_msg_mem_en, regop_msg_mem_addr, regop_pad_reg,
               regop_pad_rdy, regop_blk_idx, regop_last_blk, regop_len_err
    );
endinterface
`default_nettype wire

// File: rtl/gen_padded_multi.sv
`default_nettype none
// ============================================================================
//  Module      : gen_padded_multi
//  Description : Multi-block SHA256 message padder. Reads message bytes from
//                a synchronous SRAM and presents the padded message one
//                512-bit block at a time under a ready/ack handshake.
//                Optional macro GEN_PADDED_LEN_CHECK_EN: reject over-long
//                messages with a one-cycle regop_len_err pulse instead of
//                clamping them to MAX_MESSAGE_LENGTH.
//  Revision    : 1.0 - initial release
// ============================================================================
module gen_padded_multi #(
    parameter int MAX_MESSAGE_LENGTH = 183,
    parameter int SYMBOL_WIDTH       = 8
) (
    input  wire logic          clock,
    input  wire logic          reset,
    gen_padded_multi_if.master bus
);
    localparam int ADDR_W     = $clog2(MAX_MESSAGE_LENGTH);
    localparam int LEN_W      = $clog2(MAX_MESSAGE_LENGTH + 1);
    localparam int MAX_BLOCKS = (MAX_MESSAGE_LENGTH + 8) / 64 + 1;
    localparam int BLK_W      = ($clog2(MAX_BLOCKS) < 1) ? 1 : $clog2(MAX_BLOCKS);

    localparam logic [LEN_W-1:0] c_max_len = LEN_W'(MAX_MESSAGE_LENGTH);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_FILL     = 3'd2,
        S_READY    = 3'd3,
        S_WAIT_FIN = 3'd4
    } state_t;

    state_t             r_state;
    logic [LEN_W-1:0]   r_len;
    logic [BLK_W-1:0]   r_last_b;
    logic [BLK_W-1:0]   r_blk;
    logic               r_last_blk;
    logic [511:0]       r_pad_reg;
    logic               r_pad_rdy;
    logic               r_mem_en;
    logic [ADDR_W-1:0]  r_addr;
    logic [ADDR_W-1:0]  r_last_addr;
    logic               r_rd_vld;
    logic [5:0]         r_cap_j;
    logic [6:0]         r_blk_bytes;
    logic               r_len_err;

    logic [LEN_W-1:0]   w_len_in;
    logic               w_len_bad;
    logic [BLK_W-1:0]   w_go_last_b;
    logic               w_start;
    logic [LEN_W-1:0]   w_start_len;
    logic [BLK_W-1:0]   w_start_b;
    logic [BLK_W-1:0]   w_start_last_b;
    logic [6:0]         w_start_k;
    logic [ADDR_W-1:0]  w_start_addr;
    logic [ADDR_W-1:0]  w_start_last_addr;
    logic [9:0]         w_cap_lsb;
    logic [63:0]        w_len_bits;
    logic [511:0]       w_fill;

    // Number of message bytes that land in block blk (0..64).
    function automatic logic [6:0] blk_bytes(input logic [LEN_W-1:0] len,
                                             input logic [BLK_W-1:0] blk);
        int rem;
        rem = int'(len) - 64 * int'(blk);
        if (rem <= 0)
            return 7'd0;
        else if (rem >= 64)
            return 7'd64;
        else
            return 7'(rem);
    endfunction

`ifdef GEN_PADDED_LEN_CHECK_EN
    assign w_len_in  = bus.msg_len;
    assign w_len_bad = (bus.msg_len > c_max_len);
`else
    assign w_len_in  = (bus.msg_len > c_max_len) ? c_max_len : bus.msg_len;
    assign w_len_bad = 1'b0;
`endif

    // Block start happens on an accepted go or on an ack of a non-final block.
    always_comb begin
        w_go_last_b       = BLK_W'((int'(w_len_in) + 8) / 64);
        w_start           = ((r_state == S_IDLE) && bus.main_go_sig && !w_len_bad) ||
                            ((r_state == S_READY) && bus.blk_ack && (r_blk != r_last_b));
        w_start_len       = (r_state == S_IDLE) ? w_len_in : r_len;
        w_start_b         = (r_state == S_IDLE) ? '0 : r_blk + BLK_W'(1);
        w_start_last_b    = (r_state == S_IDLE) ? w_go_last_b : r_last_b;
        w_start_k         = blk_bytes(w_start_len, w_start_b);
        w_start_addr      = ADDR_W'(64 * int'(w_start_b));
        w_start_last_addr = ADDR_W'(64 * int'(w_start_b) + int'(w_start_k) - 1);
        w_cap_lsb         = 10'd504 - {1'b0, r_cap_j, 3'b000};
    end

    // Overlay the 0x80 marker and, in the final block, the bit length.
    always_comb begin
        w_len_bits = 64'(r_len) << 3;
        w_fill     = r_pad_reg;
        for (int j = 0; j < 64; j++) begin
            if (64 * int'(r_blk) + j == int'(r_len))
                w_fill[511 - 8*j -: 8] = 8'h80;
        end
        for (int j = 56; j < 64; j++) begin
            if (r_last_blk)
                w_fill[511 - 8*j -: 8] = w_len_bits[8*(63 - j) +: 8];
        end
    end

    // Control FSM: address issue, byte capture, padding and handshake.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_last_b    <= '0;
            r_blk       <= '0;
            r_last_blk  <= 1'b0;
            r_pad_reg   <= '0;
            r_pad_rdy   <= 1'b0;
            r_mem_en    <= 1'b0;
            r_addr      <= '0;
            r_last_addr <= '0;
            r_rd_vld    <= 1'b0;
            r_cap_j     <= '0;
            r_blk_bytes <= '0;
            r_len_err   <= 1'b0;
        end else begin
            r_len_err <= 1'b0;
            r_rd_vld  <= r_mem_en;
            case (r_state)
                S_IDLE: begin
                    if (bus.main_go_sig) begin
                        if (w_len_bad) begin
                            r_len_err <= 1'b1;
                        end else begin
                            r_len    <= w_len_in;
                            r_last_b <= w_go_last_b;
                        end
                    end
                end
                S_FETCH: begin
                    if (r_mem_en) begin
                        if (r_addr == r_last_addr)
                            r_mem_en <= 1'b0;
                        else
                            r_addr <= r_addr + ADDR_W'(1);
                    end
                    // SRAM data returns two edges after the address is registered.
                    if (r_rd_vld) begin
                        r_pad_reg[w_cap_lsb +: SYMBOL_WIDTH] <= bus.msg_mem_data;
                        r_cap_j <= r_cap_j + 6'd1;
                        if ({1'b0, r_cap_j} == r_blk_bytes - 7'd1)
                            r_state <= S_FILL;
                    end
                end
                S_FILL: begin
                    r_pad_reg <= w_fill;
                    r_pad_rdy <= 1'b1;
                    r_state   <= S_READY;
                end
                S_READY: begin
                    if (bus.blk_ack) begin
                        r_pad_rdy <= 1'b0;
                        if (r_blk == r_last_b)
                            r_state <= S_WAIT_FIN;
                    end
                end
                S_WAIT_FIN: begin
                    if (bus.finish_sig)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase

            // Block setup; the first address goes out on the start edge itself.
            if (w_start) begin
                r_blk       <= w_start_b;
                r_last_blk  <= (w_start_b == w_start_last_b);
                r_pad_reg   <= '0;
                r_cap_j     <= '0;
                r_blk_bytes <= w_start_k;
                r_addr      <= w_start_addr;
                r_last_addr <= w_start_last_addr;
                r_mem_en    <= (w_start_k != 7'd0);
                r_state     <= (w_start_k != 7'd0) ? S_FETCH : S_FILL;
            end
        end
    end

    assign bus.regop_msg_mem_en   = r_mem_en;
    assign bus.regop_msg_mem_addr = r_addr;
    assign bus.regop_pad_reg      = r_pad_reg;
    assign bus.regop_pad_rdy      = r_pad_rdy;
    assign bus.regop_blk_idx      = r_blk;
    assign bus.regop_last_blk     = r_last_blk;
    assign bus.regop_len_err      = r_len_err;

endmodule
`default_nettype wire

// File: tb/tb_gen_padded_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gen_padded_multi
//  Description : Directed self-checking bench for gen_padded_multi with a
//                synchronous SRAM model and a byte-level padding model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gen_padded_multi;
    localparam int MAX_MESSAGE_LENGTH = 183;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    gen_padded_multi_if #(.MAX_MESSAGE_LENGTH(MAX_MESSAGE_LENGTH)) bus ();

    gen_padded_multi #(.MAX_MESSAGE_LENGTH(MAX_MESSAGE_LENGTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] mem [0:255];
    int n_tests = 0;
    int n_fail  = 0;
    int en_cnt  = 0;
    int err_cnt = 0;

    // Synchronous-read SRAM: data valid the cycle after en/addr are sampled.
    always @(posedge clock) begin
        if (bus.regop_msg_mem_en)
            bus.msg_mem_data <= mem[bus.regop_msg_mem_addr];
    end

    // Running totals of issued reads and error pulses.
    always @(posedge clock) begin
        if (bus.regop_msg_mem_en) en_cnt  <= en_cnt + 1;
        if (bus.regop_len_err)    err_cnt <= err_cnt + 1;
    end

    task automatic check_value(input string tag, input logic [511:0] act,
                               input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Expected block b of a padded message of len bytes.
    function automatic logic [511:0] exp_block(input int len, input int b);
        logic [511:0] r;
        logic [63:0]  lb;
        logic [63:0]  sh;
        int nb;
        int g;
        r  = '0;
        lb = 64'(len) * 64'd8;
        nb = (len + 8) / 64 + 1;
        for (int j = 0; j < 64; j++) begin
            g = 64 * b + j;
            if (g < len)
                r[511 - 8*j -: 8] = mem[g];
            else if (g == len)
                r[511 - 8*j -: 8] = 8'h80;
            else if ((b == nb - 1) && (j >= 56)) begin
                sh = lb >> (8 * (63 - j));
                r[511 - 8*j -: 8] = sh[7:0];
            end
        end
        return r;
    endfunction

    task automatic start_run(input int len);
        bus.msg_len     = 8'(len);
        bus.main_go_sig = 1'b1;
        @(posedge clock); #1;
        bus.main_go_sig = 1'b0;
    endtask

    task automatic wait_rdy(input string tag, input int exp_edges);
        int e;
        e = 0;
        while (!bus.regop_pad_rdy && e < 300) begin
            @(posedge clock); #1;
            e++;
        end
        check_value(tag, 512'(e), 512'(exp_edges));
    endtask

    task automatic ack_blk();
        bus.blk_ack = 1'b1;
        @(posedge clock); #1;
        bus.blk_ack = 1'b0;
    endtask

    task automatic end_run();
        bus.finish_sig = 1'b1;
        @(posedge clock); #1;
        bus.finish_sig = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check_value({tag, "_pad"}, bus.regop_pad_reg, '0);
        check_value({tag, "_ctrl"}, 512'({bus.regop_pad_rdy, bus.regop_msg_mem_en,
                    bus.regop_msg_mem_addr, bus.regop_blk_idx, bus.regop_last_blk,
                    bus.regop_len_err}), '0);
    endtask

    // Three-block run of len bytes with delayed acks and ignored go pulses.
    task automatic run_long(input string tag, input int len);
        int base;
        base = en_cnt;
        start_run(len);
        for (int b = 0; b < 3; b++) begin
            wait_rdy({tag, "_lat"}, (b < 2) ? 66 : 57);
            check_value({tag, "_pad"}, bus.regop_pad_reg, exp_block(183, b));
            check_value({tag, "_idx"}, 512'(bus.regop_blk_idx), 512'(b));
            check_value({tag, "_last"}, 512'(bus.regop_last_blk), 512'(b == 2));
            repeat (3) @(posedge clock);
            #1;
            bus.msg_len     = 8'd5;
            bus.main_go_sig = 1'b1;
            @(posedge clock); #1;
            bus.main_go_sig = 1'b0;
            repeat (6) @(posedge clock);
            #1;
            check_value({tag, "_hold"}, bus.regop_pad_reg, exp_block(183, b));
            check_value({tag, "_hold_rdy"}, 512'(bus.regop_pad_rdy), 512'(1));
            if (b == 2) begin
                check_value({tag, "_mark"}, 512'(bus.regop_pad_reg[511 - 8*55 -: 8]), 512'(8'h80));
                check_value({tag, "_len"}, 512'(bus.regop_pad_reg[63:0]), 512'(64'h5B8));
            end
            ack_blk();
            check_value({tag, "_rdy_fall"}, 512'(bus.regop_pad_rdy), 512'(0));
        end
        check_value({tag, "_reads"}, 512'(en_cnt - base), 512'(183));
        end_run();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int ebase;
        reset            = 1'b1;
        bus.main_go_sig  = 1'b0;
        bus.msg_len      = '0;
        bus.blk_ack      = 1'b0;
        bus.finish_sig   = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);
        mem[0] = 8'h61; mem[1] = 8'h62; mem[2] = 8'h63;
        repeat (3) @(posedge clock);
        #1;
        check_zero_outputs("rst");
        reset = 1'b0;
        @(posedge clock); #1;

        // "abc"
        base = en_cnt;
        start_run(3);
        wait_rdy("abc_lat", 5);
        check_value("abc_pad", bus.regop_pad_reg, {32'h61626380, 416'h0, 64'h18});
        check_value("abc_last", 512'(bus.regop_last_blk), 512'(1));
        check_value("abc_idx", 512'(bus.regop_blk_idx), 512'(0));
        check_value("abc_reads", 512'(en_cnt - base), 512'(3));
        ack_blk();
        check_value("abc_rdy_fall", 512'(bus.regop_pad_rdy), 512'(0));
        end_run();

        // Empty message
        base = en_cnt;
        start_run(0);
        wait_rdy("l0_lat", 1);
        check_value("l0_pad", bus.regop_pad_reg, {8'h80, 504'h0});
        check_value("l0_last", 512'(bus.regop_last_blk), 512'(1));
        check_value("l0_reads", 512'(en_cnt - base), 512'(0));
        ack_blk();
        end_run();

        // 56 bytes: length spills into a second, empty block
        start_run(56);
        wait_rdy("l56_b0_lat", 58);
        check_value("l56_b0_pad", bus.regop_pad_reg, exp_block(56, 0));
        check_value("l56_b0_mark", 512'(bus.regop_pad_reg[511 - 8*56 -: 8]), 512'(8'h80));
        check_value("l56_b0_last", 512'(bus.regop_last_blk), 512'(0));
        ack_blk();
        wait_rdy("l56_b1_lat", 1);
        check_value("l56_b1_pad", bus.regop_pad_reg, {448'h0, 64'h1C0});
        check_value("l56_b1_idx", 512'(bus.regop_blk_idx), 512'(1));
        check_value("l56_b1_last", 512'(bus.regop_last_blk), 512'(1));
        ack_blk();
        end_run();

        // Maximum length, slow core
        run_long("l183", 183);

        // Reset during FETCH of block 1, then a clean short run
        start_run(100);
        wait_rdy("abort_b0_lat", 66);
        ack_blk();
        repeat (4) @(posedge clock);
        #1;
        check_value("abort_fetching", 512'(bus.regop_msg_mem_en), 512'(1));
        reset       = 1'b1;
        bus.blk_ack = 1'b1;
        @(posedge clock); #1;
        bus.blk_ack = 1'b0;
        check_zero_outputs("abort_rst");
        @(posedge clock); #1;
        reset = 1'b0;
        base = en_cnt;
        start_run(7);
        wait_rdy("l7_lat", 9);
        check_value("l7_pad", bus.regop_pad_reg, exp_block(7, 0));
        check_value("l7_last", 512'(bus.regop_last_blk), 512'(1));
        check_value("l7_idx", 512'(bus.regop_blk_idx), 512'(0));
        check_value("l7_reads", 512'(en_cnt - base), 512'(7));
        ack_blk();
        end_run();

        // Over-long message
`ifdef GEN_PADDED_LEN_CHECK_EN
        base  = en_cnt;
        ebase = err_cnt;
        start_run(200);
        check_value("l200_err_hi", 512'(bus.regop_len_err), 512'(1));
        @(posedge clock); #1;
        check_value("l200_err_lo", 512'(bus.regop_len_err), 512'(0));
        repeat (20) @(posedge clock);
        #1;
        check_value("l200_no_rdy", 512'(bus.regop_pad_rdy), 512'(0));
        check_value("l200_reads", 512'(en_cnt - base), 512'(0));
        check_value("l200_pulses", 512'(err_cnt - ebase), 512'(1));
        start_run(0);
        wait_rdy("l200_after_lat", 1);
        ack_blk();
        end_run();
`else
        ebase = err_cnt;
        run_long("l200", 200);
        check_value("l200_no_err", 512'(err_cnt - ebase), 512'(0));
        check_value("no_err_total", 512'(err_cnt), 512'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
